// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-controlled power-of-two clock divider controller. While running it
// produces a one-cycle tick once every 2^(cur_sel+1) clocks. It can also
// produce a registered 50% square wave with the same period. A new ratio is
// offered over a valid/ready handshake. It takes effect only at a period
// boundary, so no runt periods are produced. Stopping also waits for the end
// of the current period.
//
// Build option:
//   CLK_DIV_CTRL_DIVOUT_EN  defined   -> div_out square wave register is built
//                           undefined -> div_out is tied to 0
//
// Parameters:
//   WIDTH  counter width (>= 2); maximum division 2^WIDTH
//   SEL_W  width of the ratio code
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   run request (level)
//   sel_valid  in   new ratio code offered
//   sel_data   in   ratio code n, divide by 2^(n+1); codes >= WIDTH clamp
//   sel_ready  out  ratio offer can be accepted (not PENDING)
//   cur_sel    out  ratio code currently in effect
//   tick       out  one-cycle strobe at each period end
//   div_out    out  registered square wave, period 2^(cur_sel+1)
//   running    out  state is not IDLE
//   busy       out  a ratio change is pending
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sel_valid,
   input  logic [SEL_W-1:0] sel_data,
   output logic             sel_ready,
   output logic [SEL_W-1:0] cur_sel,
   output logic             tick,
   output logic             div_out,
   output logic             running,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PENDING = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_next;
   logic [WIDTH-1:0] w_cnt_inc;
   logic [WIDTH-1:0] w_mask;
   logic [SEL_W-1:0] r_cur_sel;
   logic [SEL_W-1:0] w_cur_sel_next;
   logic [SEL_W-1:0] r_pend_sel;
   logic [SEL_W-1:0] w_pend_sel_next;
   logic [SEL_W-1:0] w_sel_clamped;
   logic [SEL_W:0]   w_shamt;
   logic             r_tick;
   logic             w_tick_next;
   logic             w_accept;
   logic             w_terminal;

   // Handshake and status outputs decode directly from the state register.
   assign sel_ready = (r_state != S_PENDING);
   assign running   = (r_state != S_IDLE);
   assign busy      = (r_state == S_PENDING);
   assign cur_sel   = r_cur_sel;
   assign tick      = r_tick;

   assign w_accept  = sel_valid & sel_ready;
   assign w_cnt_inc = r_cnt + WIDTH'(1);

   // The shift amount is one bit wider than the code so that code WIDTH-1
   // (shift by WIDTH) yields an all-ones mask rather than overflowing.
   assign w_shamt    = {1'b0, r_cur_sel} + (SEL_W + 1)'(1);
   assign w_mask     = ~({WIDTH{1'b1}} << w_shamt);
   assign w_terminal = (r_state != S_IDLE) && ((r_cnt & w_mask) == w_mask);

   // Codes that would need more counter bits than exist select the slowest ratio.
   assign w_sel_clamped = (int'(sel_data) > WIDTH - 1) ? SEL_W'(WIDTH - 1) : sel_data;

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_cur_sel_next  = r_cur_sel;
      w_pend_sel_next = r_pend_sel;
      w_tick_next     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (w_accept) begin
               w_cur_sel_next = w_sel_clamped;
            end
            if (enable) begin
               w_state_next = S_RUN;
            end
         end

         S_RUN: begin
            w_cnt_next = w_cnt_inc;
            if (w_terminal) begin
               w_tick_next = 1'b1;
            end
            if (w_terminal && !enable) begin
               // Stop at the period end. A ratio accepted on this same edge is
               // applied rather than dropped.
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
               if (w_accept) begin
                  w_cur_sel_next = w_sel_clamped;
               end
            end else if (w_accept) begin
               // Even when accepted on a terminal edge, the new ratio waits for
               // the next terminal edge so the period just begun stays whole.
               w_pend_sel_next = w_sel_clamped;
               w_state_next    = S_PENDING;
            end
         end

         S_PENDING: begin
            w_cnt_next = w_cnt_inc;
            if (w_terminal) begin
               // Last old-ratio tick coincides with the switch; the new ratio
               // starts from a fresh count.
               w_tick_next    = 1'b1;
               w_cur_sel_next = r_pend_sel;
               w_cnt_next     = '0;
               w_state_next   = enable ? S_RUN : S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_cur_sel  <= '0;
         r_pend_sel <= '0;
         r_tick     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_cur_sel  <= w_cur_sel_next;
         r_pend_sel <= w_pend_sel_next;
         r_tick     <= w_tick_next;
      end
   end

   // -----------------------------------------------------------------------
   // Optional square-wave output
   // -----------------------------------------------------------------------
`ifdef CLK_DIV_CTRL_DIVOUT_EN
   logic r_div_out;
   logic w_div_next;

   // Bit cur_sel of the upcoming count is high for the second half of each
   // period. Terminal edges and IDLE force the wave low, so every period
   // (and every restart) begins from a low level.
   always_comb begin
      w_div_next = 1'b0;
      if ((r_state != S_IDLE) && !w_terminal) begin
         w_div_next = w_cnt_inc[r_cur_sel];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_out <= 1'b0;
      end else begin
         r_div_out <= w_div_next;
      end
   end

   assign div_out = r_div_out;
`else
   assign div_out = 1'b0;
`endif

endmodule
